// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : pwm_peripheral
// Purpose  : Fixed-frequency 8-bit PWM driving 16 enable/mode-gated outputs.
//            Optional macro PWM_SHADOW_EN: duty is latched at period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_out_7_0,
    input  logic [7:0]  en_out_15_8,
    input  logic [7:0]  en_pwm_7_0,
    input  logic [7:0]  en_pwm_15_8,
    input  logic [7:0]  pwm_duty,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int                 c_PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_DIV - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [7:0]         r_cnt;
    logic               w_tick;
    logic [7:0]         w_duty_act;
    logic               w_lvl;
    logic [15:0]        w_en_out;
    logic [15:0]        w_en_pwm;
    logic [15:0]        w_out_nxt;

    assign w_tick = (r_pre == c_PRE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_cnt <= 8'd0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + c_PRE_W'(1);
            if (w_tick) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] r_duty_act;

    // Loaded only on the last cycle of a period so every period is whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_act <= 8'h00;
        end else if (w_tick && (r_cnt == 8'hFF)) begin
            r_duty_act <= pwm_duty;
        end
    end

    assign w_duty_act = r_duty_act;
`else
    assign w_duty_act = pwm_duty;
`endif

    // 0xFF is special-cased so full scale is truly 100 %, not 255/256.
    assign w_lvl     = (w_duty_act == 8'hFF) || (r_cnt < w_duty_act);
    assign w_en_out  = {en_out_15_8, en_out_7_0};
    assign w_en_pwm  = {en_pwm_15_8, en_pwm_7_0};
    assign w_out_nxt = w_en_out & (~w_en_pwm | {16{w_lvl}});

    always_ff @(posedge clk) begin
        if (rst) begin
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            out          <= w_out_nxt;
            period_start <= (r_pre == '0) && (r_cnt == 8'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_peripheral
// Purpose  : Directed self-checking bench for pwm_peripheral (CLK_DIV 13 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_peripheral;

`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] a_en_out;
    logic [15:0] a_en_pwm;
    logic [7:0]  a_duty;
    logic [15:0] a_out;
    logic        a_ps;
    logic [15:0] b_en;
    logic [7:0]  b_duty;
    logic [15:0] b_out;
    logic        b_ps;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];

    pwm_peripheral #(.CLK_DIV(13)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .en_out_7_0   (a_en_out[7:0]),
        .en_out_15_8  (a_en_out[15:8]),
        .en_pwm_7_0   (a_en_pwm[7:0]),
        .en_pwm_15_8  (a_en_pwm[15:8]),
        .pwm_duty     (a_duty),
        .out          (a_out),
        .period_start (a_ps)
    );

    pwm_peripheral #(.CLK_DIV(1)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .en_out_7_0   (b_en[7:0]),
        .en_out_15_8  (b_en[15:8]),
        .en_pwm_7_0   (b_en[7:0]),
        .en_pwm_15_8  (b_en[15:8]),
        .pwm_duty     (b_duty),
        .out          (b_out),
        .period_start (b_ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL %s: observed %0d expected <nothing queued>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
            end
        end
    endtask

    task automatic wait_ps(input bit sel, input string tag);
        int   n;
        logic p;
        push(32'd1);
        n = 0;
        p = sel ? b_ps : a_ps;
        while (p !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
            p = sel ? b_ps : a_ps;
        end
        check(tag, {31'd0, p === 1'b1});
    endtask

    // Entered on the negedge where period_start is high; returns on the next one.
    task automatic measure(input bit sel, input int chg_at, input logic [7:0] chg_val,
                           input logic [15:0] m_pwm, input logic [15:0] m_static,
                           output int high, output int len, output int bad,
                           output logic first0, output logic last0);
        logic [15:0] o;
        logic        p;
        high = 0;
        len  = 0;
        bad  = 0;
        o      = sel ? b_out : a_out;
        first0 = o[0];
        last0  = 1'b0;
        do begin
            if (!sel && len == chg_at) a_duty = chg_val;
            o = sel ? b_out : a_out;
            if (o[0] === 1'b1) high++;
            if (o !== ((m_pwm & {16{o[0]}}) | m_static)) bad++;
            last0 = o[0];
            len++;
            @(negedge clk);
            p = sel ? b_ps : a_ps;
        end while (p !== 1'b1 && len < 4000);
    endtask

    task automatic run_period(input string tag, input bit sel, input int chg_at,
                              input logic [7:0] chg_val, input logic [15:0] m_pwm,
                              input logic [15:0] m_static, input int exp_high,
                              input int exp_len, input int exp_first, input int exp_last);
        int   h;
        int   l;
        int   b;
        logic f;
        logic z;
        push(32'(exp_high));
        push(32'(exp_len));
        push(32'd0);
        if (exp_first >= 0) push(32'(exp_first));
        if (exp_last >= 0) push(32'(exp_last));
        measure(sel, chg_at, chg_val, m_pwm, m_static, h, l, b, f, z);
        check({tag, "_high"}, 32'(h));
        check({tag, "_len"}, 32'(l));
        check({tag, "_pattern"}, 32'(b));
        if (exp_first >= 0) check({tag, "_first"}, {31'd0, f});
        if (exp_last >= 0) check({tag, "_last"}, {31'd0, z});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        a_en_out = 16'h0001;
        a_en_pwm = 16'h0001;
        a_duty   = 8'h80;
        b_en     = 16'h0001;
        b_duty   = 8'h03;

        repeat (3) @(negedge clk);
        push(32'd0); check("reset_out", 32'(a_out));
        push(32'd0); check("reset_ps", 32'(a_ps));
        push(32'd0); check("reset_out_b", 32'(b_out));
        rst = 1'b0;
        @(negedge clk);
        push(32'd1); check("first_ps", 32'(a_ps));

        run_period("p1_d80", 1'b0, -1, 8'h00, 16'h0001, 16'h0000,
                   SHADOW ? 0 : 1664, 3328, SHADOW ? 0 : 1, -1);
        run_period("p2_d80", 1'b0, -1, 8'h00, 16'h0001, 16'h0000, 1664, 3328, 1, 0);

        a_duty = 8'h00;
        @(negedge clk);
        wait_ps(1'b0, "sync_d00");
        run_period("d00_a", 1'b0, -1, 8'h00, 16'h0001, 16'h0000, 0, 3328, 0, 0);
        run_period("d00_b", 1'b0, -1, 8'h00, 16'h0001, 16'h0000, 0, 3328, 0, 0);

        a_duty = 8'hFF;
        @(negedge clk);
        wait_ps(1'b0, "sync_dff");
        run_period("dff_a", 1'b0, -1, 8'h00, 16'h0001, 16'h0000, 3328, 3328, 1, 1);
        run_period("dff_b", 1'b0, -1, 8'h00, 16'h0001, 16'h0000, 3328, 3328, 1, 1);

        a_en_out = 16'hFFFF;
        a_en_pwm = 16'h00FF;
        a_duty   = 8'h40;
        @(negedge clk);
        wait_ps(1'b0, "sync_mix");
        run_period("mix_d40", 1'b0, -1, 8'h00, 16'h00FF, 16'hFF00, 832, 3328, 1, 0);

        a_en_out = 16'h0000;
        @(negedge clk);
        push(32'd0); check("en_off_out", 32'(a_out));

        a_en_out = 16'h0001;
        a_en_pwm = 16'h0001;
        @(negedge clk);
        wait_ps(1'b0, "sync_chg");
        // Duty raised to 0xC0 while cnt = 100.
        run_period("chg_cur", 1'b0, 1300, 8'hC0, 16'h0001, 16'h0000,
                   SHADOW ? 832 : 2027, 3328, 1, 0);
        run_period("chg_next", 1'b0, -1, 8'h00, 16'h0001, 16'h0000, 2496, 3328, 1, 0);

        repeat (1000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push(32'd0); check("rst77_out", 32'(a_out));
        push(32'd0); check("rst77_ps", 32'(a_ps));
        rst = 1'b0;
        @(negedge clk);
        push(32'd1); check("rst77_ps_next", 32'(a_ps));
        run_period("post_rst", 1'b0, -1, 8'h00, 16'h0001, 16'h0000,
                   SHADOW ? 0 : 2496, 3328, SHADOW ? 0 : 1, -1);
        run_period("post_rst2", 1'b0, -1, 8'h00, 16'h0001, 16'h0000, 2496, 3328, 1, 0);

        wait_ps(1'b1, "sync_b");
        run_period("b_d03", 1'b1, -1, 8'h00, 16'h0001, 16'h0000, 3, 256, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
